ysyx_210544_trap_ctrl: RTL and testbench
========================================

Name: ysyx_210544_trap_ctrl

Overview:
- Trap sequencer directly upstream of the CSR file; sole driver of the CSR file's single read/write port while a trap or mret is in flight.
- On ecall, mret or an enabled machine timer interrupt, steps through the required CSR reads and writes: mstatus, mepc, mcause, mtvec.
- Finishes with a one-cycle PC redirect to the fetch stage.
- Machine mode only; one trap serviced at a time.

Parameters:
- XLEN, 64, data width of CSR and PC buses.
- MCAUSE_ECALL_M, 64'd11, cause code written for ecall.
- MCAUSE_MTI, 64'h8000_0000_0000_0007, cause code written for machine timer interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_inst_valid  in  1  commit-stage instruction valid
- i_inst_pc  in  64  PC of the committing instruction
- i_ecall  in  1  committing instruction is ecall
- i_mret  in  1  committing instruction is mret
- i_clint_mtip  in  1  timer pending from CLINT
- i_csr_mstatus_mie  in  1  mstatus.MIE from CSR file
- i_csr_mie_mtie  in  1  mie.MTIE from CSR file
- o_ready  out  1  high only in IDLE; request accepted when i_inst_valid & o_ready
- o_busy  out  1  high in every non-IDLE state; stalls commit
- o_csr_ren  out  1  CSR read enable
- o_csr_addr  out  12  CSR address
- o_csr_wen  out  1  CSR write enable
- o_csr_wdata  out  64  CSR write data
- i_csr_rdata  in  64  CSR read data, combinational, same cycle as ren
- o_redirect_valid  out  1  one-cycle redirect pulse
- o_redirect_pc  out  64  redirect target

Behaviour:
- Clock, reset: single clock; synchronous active-high reset on clk and rst.
- Reset values: state=IDLE; o_redirect_valid=0, o_redirect_pc=0, o_csr_ren=0, o_csr_wen=0, o_csr_addr=0, o_csr_wdata=0; internal regs (saved PC, mstatus copy, cause) =0.
- Reset mid-sequence: abort to IDLE; no further CSR write issued.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- Accept condition (IDLE only):
  - irq = i_clint_mtip & i_csr_mstatus_mie & i_csr_mie_mtie.
  - irq is evaluated every IDLE cycle regardless of i_inst_valid.
- Priority when events coincide: irq > ecall > mret.
  - irq with valid instruction: mepc = i_inst_pc; the instruction is not committed; commit stalls on o_busy.
  - irq without valid instruction: mepc = last accepted PC register.
  - ecall and mret both asserted: treated as ecall.
- Trap path (irq/ecall), one state per cycle:
  - IDLE -> T_RD_MST: ren, addr 0x300; capture rdata.
  - -> T_WR_EPC: wen 0x341, wdata = saved PC with bits[1:0] cleared.
  - -> T_WR_CAU: wen 0x342, wdata = cause.
  - -> T_WR_MST: wen 0x300; wdata = captured mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(12:11)=2'b11.
  - -> T_RD_VEC: ren 0x305; target = {rdata[63:2],2'b00}.
  - -> REDIR: o_redirect_valid=1, o_redirect_pc=target.
  - -> IDLE.
  - Redirect appears 6 cycles after the accept edge.
- Mret path:
  - IDLE -> R_RD_MST: capture mstatus.
  - -> R_RD_EPC: ren 0x341; target = rdata.
  - -> R_WR_MST: MIE=old MPIE, MPIE=1, MPP=2'b00.
  - -> REDIR -> IDLE.
  - Redirect 4 cycles after accept.
- Port exclusivity: never ren and wen in the same cycle; both 0 in IDLE and REDIR.
- Interrupt masking: irq cannot retrigger during a sequence; after the trap's mstatus write, MIE=0 masks the returned irq.

Optional Feature:
- Macro: YSYX_210544_TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the trap is an interrupt, target = {mtvec[63:2],2'b00} + 4*cause[62:0] (MTI -> base+0x1C). Exceptions always use base.
- Undefined: mtvec[1:0] ignored; direct mode always.

Decomposition:
- Shared defines file:
  - CSR address constants (CSR_ADR_*), already present.
  - New cause constants.
  - Trap state encodings TRAP_ST_* (4-bit).
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
- One sub-module: ysyx_210544_trap_vec_calc, combinational mtvec+cause -> target PC; holds the optional vectored logic.

Test Plan:
- ecall at pc 0x8000_0104, mtvec=0x8000_0200, mstatus=0x1808:
  - mepc=0x8000_0104, mcause=11, mstatus=0x1880.
  - redirect to 0x8000_0200 exactly 6 cycles after accept.
  - o_busy high 6 cycles.
- mret with mepc=0x8000_0108, mstatus=0x1880:
  - mstatus=0x0088.
  - redirect to 0x8000_0108 after 4 cycles.
- mtip=1, MIE=1, MTIE=1 coinciding with ecall at 0x8000_0010:
  - mcause=0x8000_0000_0000_0007, mepc=0x8000_0010.
  - ecall not separately serviced.
- mtip=1 with MIE=0:
  - no trap; o_ready stays 1; no CSR traffic.
- rst asserted in T_WR_CAU:
  - next cycle IDLE, all outputs 0.
  - mstatus write never issued.
- With YSYX_210544_TRAP_VECTORED_EN, mtvec=0x8000_0201, timer irq:
  - redirect 0x8000_021C.
  - ecall under same mtvec -> 0x8000_0200.

Source files
------------

// File: rtl/ysyx_210544_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, cause codes,
// sequencer state encodings and mstatus field positions.
// Optional build macro used elsewhere in this slice: YSYX_210544_TRAP_VECTORED_EN.
package ysyx_210544_trap_ctrl_pkg;

  // CSR addresses touched by the trap sequencer
  localparam logic [11:0] CSR_ADR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_ADR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADR_MCAUSE  = 12'h342;

  // Cause codes; bit 63 marks an interrupt
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

  // mstatus field positions
  localparam int MST_MIE_BIT  = 3;
  localparam int MST_MPIE_BIT = 7;
  localparam int MST_MPP_HI   = 12;
  localparam int MST_MPP_LO   = 11;

  // Privilege encodings written into MPP
  localparam logic [1:0] PRV_M = 2'b11;
  localparam logic [1:0] PRV_U = 2'b00;

  // Sequencer states: T_* is the trap path, R_* is the mret path
  typedef enum logic [3:0] {
    TRAP_ST_IDLE     = 4'd0,
    TRAP_ST_T_RD_MST = 4'd1,
    TRAP_ST_T_WR_EPC = 4'd2,
    TRAP_ST_T_WR_CAU = 4'd3,
    TRAP_ST_T_WR_MST = 4'd4,
    TRAP_ST_T_RD_VEC = 4'd5,
    TRAP_ST_REDIR    = 4'd6,
    TRAP_ST_R_RD_MST = 4'd7,
    TRAP_ST_R_RD_EPC = 4'd8,
    TRAP_ST_R_WR_MST = 4'd9
  } trap_state_e;

endpackage

// File: rtl/ysyx_210544_trap_vec_calc.sv
// Trap target calculation: mtvec (+ cause) -> redirect PC.
// Purely combinational, zero latency, no backpressure.
// With YSYX_210544_TRAP_VECTORED_EN, interrupts in vectored mode land at base + 4*cause.
module ysyx_210544_trap_vec_calc
  import ysyx_210544_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base;

  // The low two bits of mtvec are the mode field, never part of the address
  assign base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef YSYX_210544_TRAP_VECTORED_EN
  logic            is_irq;
  logic            vec_mode;
  logic [XLEN-1:0] offset;

  assign is_irq   = cause_i[XLEN-1];
  assign vec_mode = (mtvec_i[1:0] == 2'b01);
  // 4*cause with the interrupt flag dropped; the top bits fall off the bus
  assign offset   = {cause_i[XLEN-3:0], 2'b00};

  // Synchronous exceptions always enter at base, even in vectored mode
  assign target_o = (is_irq && vec_mode) ? (base + offset) : base;
`else
  logic unused_mode_cause;

  // Direct mode only: the mode bits and the cause do not affect the target
  assign unused_mode_cause = ^{mtvec_i[1:0], cause_i};
  assign target_o          = base;
`endif

endmodule

// File: rtl/ysyx_210544_trap_ctrl.sv
// Machine-mode trap/mret sequencer driving the CSR file's single port, then redirecting fetch.
// Latency: trap redirect 6 cycles after accept, mret redirect 4 cycles after accept.
// Backpressure: accepts only in IDLE (o_ready); o_busy stalls commit for the whole sequence.
// Build option: YSYX_210544_TRAP_VECTORED_EN enables vectored interrupt entry.
module ysyx_210544_trap_ctrl
  import ysyx_210544_trap_ctrl_pkg::*;
#(
  parameter int              XLEN           = 64,
  parameter logic [XLEN-1:0] MCAUSE_ECALL_M = CAUSE_ECALL_M,
  parameter logic [XLEN-1:0] MCAUSE_MTI     = CAUSE_MTI
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inst_valid,
  input  logic [XLEN-1:0] i_inst_pc,
  input  logic            i_ecall,
  input  logic            i_mret,
  input  logic            i_clint_mtip,
  input  logic            i_csr_mstatus_mie,
  input  logic            i_csr_mie_mtie,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_csr_ren,
  output logic [11:0]     o_csr_addr,
  output logic            o_csr_wen,
  output logic [XLEN-1:0] o_csr_wdata,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  trap_state_e     state_q;
  logic [XLEN-1:0] mstatus_q;   // mstatus as read at the start of the sequence
  logic [XLEN-1:0] cause_q;     // cause of the trap in flight
  logic [XLEN-1:0] epc_q;       // PC to be saved into mepc
  logic [XLEN-1:0] last_pc_q;   // PC of the most recently accepted instruction
  logic [XLEN-1:0] target_q;    // mret return address read from mepc

  logic            irq;
  logic [XLEN-1:0] mst_trap_d;
  logic [XLEN-1:0] mst_mret_d;
  logic [XLEN-1:0] vec_target;

  // Timer interrupt is only considered while idle; the sequence itself masks it
  assign irq     = i_clint_mtip & i_csr_mstatus_mie & i_csr_mie_mtie;
  assign o_ready = (state_q == TRAP_ST_IDLE);
  assign o_busy  = ~o_ready;

  // mstatus values written back on trap entry and on mret
  always_comb begin
    mst_trap_d                          = mstatus_q;
    mst_trap_d[MST_MPIE_BIT]            = mstatus_q[MST_MIE_BIT];
    mst_trap_d[MST_MIE_BIT]             = 1'b0;
    mst_trap_d[MST_MPP_HI:MST_MPP_LO]   = PRV_M;

    mst_mret_d                          = mstatus_q;
    mst_mret_d[MST_MIE_BIT]             = mstatus_q[MST_MPIE_BIT];
    mst_mret_d[MST_MPIE_BIT]            = 1'b1;
    mst_mret_d[MST_MPP_HI:MST_MPP_LO]   = PRV_U;
  end

  // The read data during T_RD_VEC is mtvec; the calculator turns it into the entry PC
  ysyx_210544_trap_vec_calc #(
    .XLEN (XLEN)
  ) u_vec_calc (
    .mtvec_i  (i_csr_rdata),
    .cause_i  (cause_q),
    .target_o (vec_target)
  );

  // Sequencer: each transition also loads the CSR/redirect outputs for the state entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= TRAP_ST_IDLE;
      mstatus_q        <= '0;
      cause_q          <= '0;
      epc_q            <= '0;
      last_pc_q        <= '0;
      target_q         <= '0;
      o_csr_ren        <= 1'b0;
      o_csr_wen        <= 1'b0;
      o_csr_addr       <= '0;
      o_csr_wdata      <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      // Port strobes are single-cycle unless a state below re-asserts them
      o_csr_ren        <= 1'b0;
      o_csr_wen        <= 1'b0;
      o_csr_addr       <= '0;
      o_csr_wdata      <= '0;
      o_redirect_valid <= 1'b0;

      case (state_q)
        TRAP_ST_IDLE: begin
          if (i_inst_valid) begin
            last_pc_q <= i_inst_pc;
          end
          // Priority irq > ecall > mret
          if (irq) begin
            cause_q    <= MCAUSE_MTI;
            epc_q      <= i_inst_valid ? i_inst_pc : last_pc_q;
            state_q    <= TRAP_ST_T_RD_MST;
            o_csr_ren  <= 1'b1;
            o_csr_addr <= CSR_ADR_MSTATUS;
          end else if (i_inst_valid && i_ecall) begin
            cause_q    <= MCAUSE_ECALL_M;
            epc_q      <= i_inst_pc;
            state_q    <= TRAP_ST_T_RD_MST;
            o_csr_ren  <= 1'b1;
            o_csr_addr <= CSR_ADR_MSTATUS;
          end else if (i_inst_valid && i_mret) begin
            state_q    <= TRAP_ST_R_RD_MST;
            o_csr_ren  <= 1'b1;
            o_csr_addr <= CSR_ADR_MSTATUS;
          end
        end

        TRAP_ST_T_RD_MST: begin
          mstatus_q   <= i_csr_rdata;
          state_q     <= TRAP_ST_T_WR_EPC;
          o_csr_wen   <= 1'b1;
          o_csr_addr  <= CSR_ADR_MEPC;
          o_csr_wdata <= {epc_q[XLEN-1:2], 2'b00};
        end

        TRAP_ST_T_WR_EPC: begin
          state_q     <= TRAP_ST_T_WR_CAU;
          o_csr_wen   <= 1'b1;
          o_csr_addr  <= CSR_ADR_MCAUSE;
          o_csr_wdata <= cause_q;
        end

        TRAP_ST_T_WR_CAU: begin
          state_q     <= TRAP_ST_T_WR_MST;
          o_csr_wen   <= 1'b1;
          o_csr_addr  <= CSR_ADR_MSTATUS;
          o_csr_wdata <= mst_trap_d;
        end

        TRAP_ST_T_WR_MST: begin
          state_q    <= TRAP_ST_T_RD_VEC;
          o_csr_ren  <= 1'b1;
          o_csr_addr <= CSR_ADR_MTVEC;
        end

        TRAP_ST_T_RD_VEC: begin
          state_q          <= TRAP_ST_REDIR;
          o_redirect_valid <= 1'b1;
          o_redirect_pc    <= vec_target;
        end

        TRAP_ST_R_RD_MST: begin
          mstatus_q  <= i_csr_rdata;
          state_q    <= TRAP_ST_R_RD_EPC;
          o_csr_ren  <= 1'b1;
          o_csr_addr <= CSR_ADR_MEPC;
        end

        TRAP_ST_R_RD_EPC: begin
          target_q    <= i_csr_rdata;
          state_q     <= TRAP_ST_R_WR_MST;
          o_csr_wen   <= 1'b1;
          o_csr_addr  <= CSR_ADR_MSTATUS;
          o_csr_wdata <= mst_mret_d;
        end

        TRAP_ST_R_WR_MST: begin
          state_q          <= TRAP_ST_REDIR;
          o_redirect_valid <= 1'b1;
          o_redirect_pc    <= target_q;
        end

        TRAP_ST_REDIR: begin
          state_q <= TRAP_ST_IDLE;
        end

        default: begin
          state_q <= TRAP_ST_IDLE;
        end
      endcase
    end
  end

  // The CSR port is shared: a read and a write must never collide
  assert property (@(posedge clk) disable iff (rst) !(o_csr_ren && o_csr_wen));

endmodule

// File: tb/tb_ysyx_210544_trap_ctrl.sv
// Scoreboard bench for ysyx_210544_trap_ctrl: stimulus pushes expected CSR/redirect events
// and expected ready/busy status per cycle; a negedge monitor pops and compares.
module tb_ysyx_210544_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_inst_valid;
  logic [63:0] i_inst_pc;
  logic        i_ecall, i_mret, i_clint_mtip, i_csr_mie_mtie;
  logic        o_ready, o_busy, o_csr_ren, o_csr_wen, o_redirect_valid;
  logic [11:0] o_csr_addr;
  logic [63:0] o_csr_wdata, o_redirect_pc, i_csr_rdata;

  always #5 clk = ~clk;

  // Small CSR file model
  logic [63:0] mst_m, mtvec_m, mepc_m, mcause_m;
  logic        set_en;
  logic [11:0] set_addr;
  logic [63:0] set_data;
  logic        m_we;
  logic [11:0] m_wa;
  logic [63:0] m_wd;

  always_comb begin
    m_we = set_en | o_csr_wen;
    m_wa = set_en ? set_addr : o_csr_addr;
    m_wd = set_en ? set_data : o_csr_wdata;
  end

  always @(posedge clk) begin
    if (m_we) begin
      case (m_wa)
        12'h300: mst_m    <= m_wd;
        12'h305: mtvec_m  <= m_wd;
        12'h341: mepc_m   <= m_wd;
        12'h342: mcause_m <= m_wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    i_csr_rdata = 64'd0;
    if (o_csr_ren) begin
      case (o_csr_addr)
        12'h300: i_csr_rdata = mst_m;
        12'h305: i_csr_rdata = mtvec_m;
        12'h341: i_csr_rdata = mepc_m;
        12'h342: i_csr_rdata = mcause_m;
        default: i_csr_rdata = 64'd0;
      endcase
    end
  end

  ysyx_210544_trap_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_inst_valid      (i_inst_valid),
    .i_inst_pc         (i_inst_pc),
    .i_ecall           (i_ecall),
    .i_mret            (i_mret),
    .i_clint_mtip      (i_clint_mtip),
    .i_csr_mstatus_mie (mst_m[3]),
    .i_csr_mie_mtie    (i_csr_mie_mtie),
    .o_ready           (o_ready),
    .o_busy            (o_busy),
    .o_csr_ren         (o_csr_ren),
    .o_csr_addr        (o_csr_addr),
    .o_csr_wen         (o_csr_wen),
    .o_csr_wdata       (o_csr_wdata),
    .i_csr_rdata       (i_csr_rdata),
    .o_redirect_valid  (o_redirect_valid),
    .o_redirect_pc     (o_redirect_pc)
  );

  // kind: {ren, wen, redirect}
  typedef struct packed {
    logic [2:0]  kind;
    logic [11:0] addr;
    logic [63:0] data;
    logic [31:0] cyc;
  } ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ready;
    logic        busy;
    logic        zero;   // additionally require every CSR/redirect output to be 0
  } st_t;

  localparam logic [2:0] K_RD = 3'b100;
  localparam logic [2:0] K_WR = 3'b010;
  localparam logic [2:0] K_RE = 3'b001;

  ev_t         ev_q[$];
  st_t         st_q[$];
  int unsigned nchk = 0;
  int unsigned npass = 0;
  logic [31:0] cyc = 0;
  logic        mon_en, fin;
  logic        fin_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares DUT output against the scoreboard queues
  always @(negedge clk) begin
    ev_t act, e;
    st_t s;
    logic zero_ok, ok;
    if (mon_en && (o_csr_ren || o_csr_wen || o_redirect_valid)) begin
      act = '{kind: {o_csr_ren, o_csr_wen, o_redirect_valid}, addr: o_csr_addr,
              data: (o_redirect_valid ? o_redirect_pc : o_csr_wdata), cyc: cyc};
      nchk++;
      if (ev_q.size() == 0) begin
        $display("FAIL unexpected_event: got kind=%b addr=%h data=%h cyc=%0d, want no traffic",
                 act.kind, act.addr, act.data, act.cyc);
      end else begin
        e = ev_q.pop_front();
        if (act == e) npass++;
        else $display("FAIL csr_event: got kind=%b addr=%h data=%h cyc=%0d, want kind=%b addr=%h data=%h cyc=%0d",
                      act.kind, act.addr, act.data, act.cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
    while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      zero_ok = !o_csr_ren && !o_csr_wen && (o_csr_addr == 12'd0) && (o_csr_wdata == 64'd0) &&
                !o_redirect_valid && (o_redirect_pc == 64'd0);
      ok = (s.cyc == cyc) && (o_ready == s.ready) && (o_busy == s.busy) && (!s.zero || zero_ok);
      nchk++;
      if (ok) npass++;
      else $display("FAIL status: cyc=%0d ready=%b busy=%b zero=%b, want cyc=%0d ready=%b busy=%b zero=%b",
                    cyc, o_ready, o_busy, zero_ok, s.cyc, s.ready, s.busy, s.zero);
    end
    if (fin && !fin_done) begin
      nchk += 2;
      if (ev_q.size() == 0) npass++;
      else $display("FAIL leftover_events: got %0d pending, want 0", ev_q.size());
      if (st_q.size() == 0) npass++;
      else $display("FAIL leftover_status: got %0d pending, want 0", st_q.size());
      fin_done = 1'b1;
    end
  end

  task automatic ev(input logic [2:0] k, input logic [11:0] a, input logic [63:0] d, input logic [31:0] c);
    ev_q.push_back('{kind: k, addr: a, data: d, cyc: c});
  endtask

  task automatic st(input logic [31:0] c, input logic r, input logic b, input logic z);
    st_q.push_back('{cyc: c, ready: r, busy: b, zero: z});
  endtask

  task automatic csr_set(input logic [11:0] a, input logic [63:0] d);
    set_en = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  // Present one instruction for a single cycle (called and returning at posedge+1)
  task automatic present(input logic [63:0] pc, input logic ec, input logic mr);
    i_inst_valid = 1'b1; i_inst_pc = pc; i_ecall = ec; i_mret = mr;
    @(posedge clk); #1;
    i_inst_valid = 1'b0; i_ecall = 1'b0; i_mret = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && (ev_q.size() != 0 || st_q.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Trap-path expectations relative to the cycle p the request is presented in
  task automatic exp_trap(input logic [31:0] p, input logic [63:0] epc, input logic [63:0] cause,
                          input logic [63:0] mst, input logic [63:0] tgt);
    ev(K_RD, 12'h300, 64'd0, p + 1);
    ev(K_WR, 12'h341, epc,   p + 2);
    ev(K_WR, 12'h342, cause, p + 3);
    ev(K_WR, 12'h300, mst,   p + 4);
    ev(K_RD, 12'h305, 64'd0, p + 5);
    ev(K_RE, 12'h000, tgt,   p + 6);
  endtask

  logic [31:0] p;
  logic [63:0] vexp;

  initial begin
`ifdef YSYX_210544_TRAP_VECTORED_EN
    vexp = 64'h8000_021C;
`else
    vexp = 64'h8000_0200;
`endif
    rst = 1'b1; i_inst_valid = 1'b0; i_inst_pc = 64'd0; i_ecall = 1'b0; i_mret = 1'b0;
    i_clint_mtip = 1'b0; i_csr_mie_mtie = 1'b0; set_en = 1'b0; set_addr = 12'd0;
    set_data = 64'd0; mon_en = 1'b0; fin = 1'b0;
    repeat (2) @(posedge clk); #1;
    csr_set(12'h300, 64'h1808);
    csr_set(12'h305, 64'h8000_0200);
    csr_set(12'h341, 64'd0);
    csr_set(12'h342, 64'd0);
    st(cyc, 1'b1, 1'b0, 1'b1);              // reset state
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b1;

    // ecall: 6-cycle trap, busy exactly 6 cycles
    p = cyc;
    exp_trap(p, 64'h8000_0104, 64'd11, 64'h1880, 64'h8000_0200);
    for (int k = 0; k <= 7; k++) st(p + k, (k == 0 || k == 7), (k >= 1 && k <= 6), 1'b0);
    present(64'h8000_0104, 1'b1, 1'b0);
    wait_drain();

    // mret: restore MIE from MPIE, redirect to mepc after 4 cycles
    csr_set(12'h341, 64'h8000_0108);
    csr_set(12'h300, 64'h1880);
    p = cyc;
    ev(K_RD, 12'h300, 64'd0,         p + 1);
    ev(K_RD, 12'h341, 64'd0,         p + 2);
    ev(K_WR, 12'h300, 64'h0088,      p + 3);
    ev(K_RE, 12'h000, 64'h8000_0108, p + 4);
    st(p + 5, 1'b1, 1'b0, 1'b0);
    present(64'h8000_0050, 1'b0, 1'b1);
    wait_drain();

    // timer irq coinciding with ecall: irq wins, ecall not serviced separately
    csr_set(12'h300, 64'h0008);
    i_csr_mie_mtie = 1'b1;
    p = cyc;
    exp_trap(p, 64'h8000_0010, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_0200);
    i_clint_mtip = 1'b1;
    present(64'h8000_0010, 1'b1, 1'b0);
    wait_drain();

    // mtip still high but MIE=0 after the trap: stays idle, no CSR traffic
    p = cyc;
    for (int k = 0; k < 8; k++) st(p + k, 1'b1, 1'b0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    wait_drain();
    i_clint_mtip = 1'b0;

    // reset while in T_WR_CAU: abort, outputs cleared, mstatus never written
    csr_set(12'h300, 64'h1808);
    p = cyc;
    ev(K_RD, 12'h300, 64'd0,         p + 1);
    ev(K_WR, 12'h341, 64'h8000_0104, p + 2);
    ev(K_WR, 12'h342, 64'd11,        p + 3);
    st(p + 4, 1'b1, 1'b0, 1'b1);
    for (int k = 5; k <= 8; k++) st(p + k, 1'b1, 1'b0, 1'b0);
    present(64'h8000_0104, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();

    // irq with no instruction: mepc from last accepted PC; mtvec mode bits set
    csr_set(12'h305, 64'h8000_0201);
    csr_set(12'h300, 64'h0008);
    present(64'h8000_0300, 1'b0, 1'b0);
    p = cyc;
    exp_trap(p, 64'h8000_0300, 64'h8000_0000_0000_0007, 64'h1880, vexp);
    i_clint_mtip = 1'b1;
    @(posedge clk); #1;
    i_clint_mtip = 1'b0;
    wait_drain();

    // ecall+mret together under the same mtvec: treated as ecall, enters at base
    p = cyc;
    exp_trap(p, 64'h8000_0400, 64'd11, 64'h1800, 64'h8000_0200);
    present(64'h8000_0400, 1'b1, 1'b1);
    wait_drain();

    fin = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
